// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: FETCH/DECODE/EXEC/WB over a req/valid IMEM port, owns pc/retired/fault.
// Latency: >=4 cycles per instruction; FETCH stretches until imem_valid or IMEM_TIMEOUT cycles.
// Backpressure: imem_req held with a stable address until imem_valid; a stalled fetch ends in HALT.
module multicycle_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          IMEM_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        halt_req,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  input  logic        dec_legal,
  input  logic        dec_reg_write,
  output logic        alu_en,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        busy,
  output logic        halted,
  output logic [1:0]  fault
);

  localparam int WW = (IMEM_TIMEOUT > 1) ? $clog2(IMEM_TIMEOUT) : 1;

  localparam logic [1:0] FAULT_NONE    = 2'd0;
  localparam logic [1:0] FAULT_ILLEGAL = 2'd1;
  localparam logic [1:0] FAULT_TIMEOUT = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WB,
    S_HALT
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [WW-1:0]   wcnt;
  logic            timeout_hit;
  logic            restart;

  assign timeout_hit = (wcnt == WW'(IMEM_TIMEOUT - 1));
  assign restart     = ((state == S_IDLE) || (state == S_HALT)) && start;

  // Strobes are decoded from state so an async reset drops them at once.
  assign imem_req  = (state == S_FETCH);
  assign imem_addr = pc;
  assign alu_en    = (state == S_EXEC);
  assign rf_we     = (state == S_WB) && dec_reg_write;
  assign busy      = (state == S_FETCH) || (state == S_DECODE) ||
                     (state == S_EXEC)  || (state == S_WB);
  assign halted    = (state == S_HALT);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_FETCH;
      S_FETCH: begin
        if (imem_valid)       state_nxt = S_DECODE;
        else if (timeout_hit) state_nxt = S_HALT;
      end
      S_DECODE: state_nxt = dec_legal ? S_EXEC : S_HALT;
      S_EXEC:   state_nxt = S_WB;
      S_WB:     state_nxt = halt_req ? S_IDLE : S_FETCH;
      S_HALT:   if (start) state_nxt = S_FETCH;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RESET_PC;
      instr   <= 32'h0;
      retired <= 32'h0;
      fault   <= FAULT_NONE;
      wcnt    <= '0;
    end else begin
      // wcnt is zero whenever FETCH is entered, since every other state clears it.
      if (state == S_FETCH && !imem_valid && !timeout_hit) wcnt <= wcnt + WW'(1);
      else                                                 wcnt <= '0;

      if (state == S_FETCH && imem_valid) instr <= imem_rdata;

      if (restart) begin
        pc      <= RESET_PC;
        retired <= 32'h0;
        fault   <= FAULT_NONE;
      end else if (state == S_WB) begin
        pc      <= pc + 32'd4;
        retired <= retired + 32'd1;
      end else if (state == S_FETCH && !imem_valid && timeout_hit) begin
        fault <= FAULT_TIMEOUT;
      end else if (state == S_DECODE && !dec_legal) begin
        fault <= FAULT_ILLEGAL;
      end
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level vector table, randomized instruction stream
// against a transaction model, and hand-written async-reset sequences.
module tb_multicycle_ctrl;

  localparam int          TO     = 16;
  localparam logic [31:0] RPC    = 32'h0000_0000;
  localparam logic [31:0] RPC_W  = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt_req, imem_valid, dec_legal, dec_reg_write;
  logic [31:0] imem_rdata;

  logic        imem_req, alu_en, rf_we, busy, halted;
  logic [31:0] imem_addr, instr, pc, retired;
  logic [1:0]  fault;

  logic        imem_req_w, alu_en_w, rf_we_w, busy_w, halted_w;
  logic [31:0] imem_addr_w, instr_w, pc_w, retired_w;
  logic [1:0]  fault_w;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_PC(RPC), .IMEM_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .instr(instr), .dec_legal(dec_legal),
    .dec_reg_write(dec_reg_write), .alu_en(alu_en), .rf_we(rf_we), .pc(pc),
    .retired(retired), .busy(busy), .halted(halted), .fault(fault)
  );

  // Same stimulus, PC starting one word below the top of the address space.
  multicycle_ctrl #(.RESET_PC(RPC_W), .IMEM_TIMEOUT(TO)) dut_w (
    .clk(clk), .rst_n(rst_n), .start(start), .halt_req(halt_req),
    .imem_req(imem_req_w), .imem_addr(imem_addr_w), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .instr(instr_w), .dec_legal(dec_legal),
    .dec_reg_write(dec_reg_write), .alu_en(alu_en_w), .rf_we(rf_we_w), .pc(pc_w),
    .retired(retired_w), .busy(busy_w), .halted(halted_w), .fault(fault_w)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: architectural state only, advanced once per instruction.
  logic [31:0] mpc;
  logic [31:0] mret;
  logic [1:0]  mfault;

  typedef struct {
    int          d;
    bit          legal;
    bit          rw;
    bit          hreq;
    logic [31:0] word;
    logic [31:0] exp_pc;
    logic [31:0] exp_ret;
    logic [1:0]  exp_fault;
  } vec_t;

  vec_t tbl[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    mpc = RPC; mret = 32'h0; mfault = 2'd0;
    chk("start_busy", {31'h0, busy}, 32'h1);
    chk("start_req", {31'h0, imem_req}, 32'h1);
    chk("start_halted", {31'h0, halted}, 32'h0);
    chk("start_fault", {30'h0, fault}, 32'h0);
    chk("start_pc", pc, RPC);
    chk("start_pc_w", pc_w, RPC_W);
    chk("start_retired", retired, 32'h0);
  endtask

  // Runs one instruction from its first FETCH cycle; outcome 0=next FETCH, 1=HALT, 2=IDLE.
  task automatic run_instr(input int d, input bit legal, input bit rw, input bit hreq,
                           input logic [31:0] word, output int outcome);
    outcome       = 0;
    dec_legal     = legal;
    dec_reg_write = rw;
    for (int k = 0; k < TO; k++) begin
      chk("fetch_req", {31'h0, imem_req}, 32'h1);
      chk("fetch_addr", imem_addr, mpc);
      chk("fetch_busy", {31'h0, busy}, 32'h1);
      chk("fetch_pc_w", pc_w, mpc + RPC_W);
      chk("fetch_strobes", {30'h0, alu_en, rf_we}, 32'h0);
      imem_valid = (k == d);
      imem_rdata = (k == d) ? word : $urandom;
      start      = 1'($urandom_range(0, 1));
      step();
      start = 1'b0;
      if (k == d) break;
    end
    imem_valid = 1'b0;
    if (d >= TO) begin
      mfault = 2'd2;
      chk("timeout_halted", {31'h0, halted}, 32'h1);
      chk("timeout_fault", {30'h0, fault}, 32'h2);
      chk("timeout_req", {31'h0, imem_req}, 32'h0);
      chk("timeout_pc", pc, mpc);
      chk("timeout_retired", retired, mret);
      outcome = 1;
      return;
    end
    chk("decode_instr", instr, word);
    chk("decode_busy", {31'h0, busy}, 32'h1);
    chk("decode_quiet", {29'h0, imem_req, alu_en, rf_we}, 32'h0);
    start    = 1'($urandom_range(0, 1));
    halt_req = 1'($urandom_range(0, 1));
    step();
    start = 1'b0; halt_req = 1'b0;
    if (!legal) begin
      mfault = 2'd1;
      chk("illegal_halted", {31'h0, halted}, 32'h1);
      chk("illegal_fault", {30'h0, fault}, 32'h1);
      chk("illegal_rf_we", {31'h0, rf_we}, 32'h0);
      chk("illegal_pc", pc, mpc);
      chk("illegal_retired", retired, mret);
      outcome = 1;
      return;
    end
    chk("exec_alu_en", {31'h0, alu_en}, 32'h1);
    chk("exec_rf_we", {31'h0, rf_we}, 32'h0);
    chk("exec_instr", instr, word);
    halt_req = 1'($urandom_range(0, 1));
    start    = 1'($urandom_range(0, 1));
    step();
    start = 1'b0;
    chk("wb_rf_we", {31'h0, rf_we}, {31'h0, rw});
    chk("wb_alu_en", {31'h0, alu_en}, 32'h0);
    chk("wb_instr", instr, word);
    chk("wb_busy", {31'h0, busy}, 32'h1);
    halt_req = hreq;
    step();
    halt_req = 1'b0;
    mpc  = mpc + 32'd4;
    mret = mret + 32'd1;
    chk("commit_pc", pc, mpc);
    chk("commit_retired", retired, mret);
    if (hreq) begin
      chk("idle_busy", {31'h0, busy}, 32'h0);
      chk("idle_req", {31'h0, imem_req}, 32'h0);
      chk("idle_halted", {31'h0, halted}, 32'h0);
      outcome = 2;
    end
  endtask

  task automatic settle(input int outcome);
    if (outcome == 1) begin
      for (int c = 0; c < 2; c++) begin
        halt_req = 1'($urandom_range(0, 1));
        step();
        chk("halt_sticky", {31'h0, halted}, 32'h1);
        chk("halt_fault", {30'h0, fault}, {30'h0, mfault});
      end
      halt_req = 1'b0;
    end else if (outcome == 2) begin
      step();
      chk("idle_req_stays", {31'h0, imem_req}, 32'h0);
      chk("idle_busy_stays", {31'h0, busy}, 32'h0);
    end
  endtask

  initial begin
    int  outcome;
    bit  need_start;
    int  d;
    bit  lg, rw, hr;

    rst_n = 1'b0; start = 1'b0; halt_req = 1'b0; imem_valid = 1'b0;
    imem_rdata = 32'h0; dec_legal = 1'b1; dec_reg_write = 1'b0;
    mpc = RPC; mret = 32'h0; mfault = 2'd0;

    #12;
    chk("rst_pc", pc, RPC);
    chk("rst_pc_w", pc_w, RPC_W);
    chk("rst_instr", instr, 32'h0);
    chk("rst_retired", retired, 32'h0);
    chk("rst_fault", {30'h0, fault}, 32'h0);
    chk("rst_flags", {27'h0, imem_req, alu_en, rf_we, busy, halted}, 32'h0);
    rst_n = 1'b1;

    for (int c = 0; c < 3; c++) begin
      halt_req = 1'($urandom_range(0, 1));
      step();
      chk("idle_wait", {30'h0, busy, imem_req}, 32'h0);
    end
    halt_req = 1'b0;

    tbl[0] = '{0,  1'b1, 1'b1, 1'b0, 32'h0050_0093, 32'd4, 32'd1, 2'd0};
    tbl[1] = '{15, 1'b1, 1'b0, 1'b0, 32'h0010_0113, 32'd8, 32'd2, 2'd0};
    tbl[2] = '{16, 1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'd8, 32'd2, 2'd2};
    tbl[3] = '{0,  1'b1, 1'b1, 1'b0, 32'h0030_0193, 32'd4, 32'd1, 2'd0};
    tbl[4] = '{1,  1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'd4, 32'd1, 2'd1};
    tbl[5] = '{2,  1'b1, 1'b1, 1'b1, 32'h0040_0213, 32'd4, 32'd1, 2'd0};
    tbl[6] = '{0,  1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'd4, 32'd1, 2'd0};

    need_start = 1'b1;
    foreach (tbl[i]) begin
      if (need_start) do_start();
      run_instr(tbl[i].d, tbl[i].legal, tbl[i].rw, tbl[i].hreq, tbl[i].word, outcome);
      chk("vec_pc", pc, tbl[i].exp_pc);
      chk("vec_pc_wrap", pc_w, tbl[i].exp_pc + RPC_W);
      chk("vec_retired", retired, tbl[i].exp_ret);
      chk("vec_fault", {30'h0, fault}, {30'h0, tbl[i].exp_fault});
      settle(outcome);
      need_start = (outcome != 0);
    end

    for (int n = 0; n < 60; n++) begin
      if (need_start) do_start();
      d  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(16, 18)) : int'($urandom_range(0, 5));
      lg = ($urandom_range(0, 9) != 0);
      rw = 1'($urandom_range(0, 1));
      hr = ($urandom_range(0, 9) == 0);
      run_instr(d, lg, rw, hr, $urandom, outcome);
      chk("rnd_retired_w", retired_w, mret);
      settle(outcome);
      need_start = (outcome != 0);
    end

    // Async reset while a fetch is outstanding.
    if (need_start) do_start();
    imem_valid = 1'b0;
    step();
    step();
    chk("pre_rst_fetch_req", {31'h0, imem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_fetch_req", {31'h0, imem_req}, 32'h0);
    chk("rst_fetch_busy", {31'h0, busy}, 32'h0);
    chk("rst_fetch_pc", pc, RPC);
    chk("rst_fetch_retired", retired, 32'h0);
    #10;
    rst_n = 1'b1;
    step();

    // Async reset in WB: the write strobe drops and the commit never happens.
    do_start();
    dec_legal = 1'b1; dec_reg_write = 1'b1;
    imem_valid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_valid = 1'b0;
    step();
    step();
    chk("pre_rst_wb_rf_we", {31'h0, rf_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_wb_rf_we", {31'h0, rf_we}, 32'h0);
    chk("rst_wb_busy", {31'h0, busy}, 32'h0);
    chk("rst_wb_pc", pc, RPC);
    chk("rst_wb_retired", retired, 32'h0);
    chk("rst_wb_instr", instr, 32'h0);
    #10;
    rst_n = 1'b1;
    step();
    chk("post_rst_pc", pc, RPC);
    chk("post_rst_retired", retired, 32'h0);
    chk("post_rst_idle", {30'h0, busy, halted}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
